delta_cmd_gen: RTL
==================

Name: delta_cmd_gen

Overview:
Upstream command stage for the team's up/down delta counter. Accepts two independent valid/ready streams, increment requests and decrement requests, each carrying a delta magnitude. Same-cycle requests are netted into a single registered command: direction plus magnitude. The downstream counter consumes the command directly: en_i = cmd_valid_o & cmd_ready_i, down_i = cmd_down_o, delta_i = cmd_delta_o.

Parameters:
WIDTH, 8, delta magnitude width; must match downstream counter WIDTH
STAT_WIDTH, 16, width of statistics counters (optional feature only)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
clear_i  input  1  synchronous flush of pending command; asserted alongside downstream clear_i
inc_valid_i  input  1  increment request valid
inc_ready_o  output  1  increment request ready
inc_delta_i  input  WIDTH  increment magnitude
dec_valid_i  input  1  decrement request valid
dec_ready_o  output  1  decrement request ready
dec_delta_i  input  WIDTH  decrement magnitude
cmd_valid_o  output  1  registered command valid
cmd_ready_i  input  1  downstream accepts command
cmd_down_o  output  1  1 = subtract, 0 = add
cmd_delta_o  output  WIDTH  command magnitude, never 0 while cmd_valid_o=1

Behaviour:
- Reset: asynchronous, active-low. Clock is clk_i, reset is rst_ni. cmd_valid_o=0, cmd_down_o=0, cmd_delta_o=0. Stats are zeroed. Reset takes effect immediately, including mid-handshake; a held command is lost.
- Output register state: valid_q, down_q, delta_q.
- can_accept = !valid_q | cmd_ready_i.
- inc_ready_o = dec_ready_o = can_accept & !clear_i. Combinational; no dependence on the *_valid_i inputs.
- Fire conditions: inc_fire = inc_valid_i & inc_ready_o; dec_fire likewise.
- Netting, computed at WIDTH+1 bits:
  - inc only: up, inc_delta_i.
  - dec only: down, dec_delta_i.
  - both fire, inc > dec: up, inc-dec.
  - both fire, dec > inc: down, dec-inc.
  - both fire, equal: no command; this is a cancelled pair.
- Magnitude always fits WIDTH bits; no saturation is needed.
- Zero-magnitude result (a single zero delta, or a cancelled pair): the request is consumed and no command is produced.
- Register update when can_accept & !clear_i: valid_q <= (netted magnitude != 0); down_q/delta_q are loaded only when the new valid is 1, otherwise they hold.
- Latency: request accepted at edge N, so cmd_valid_o=1 is visible after edge N; one cycle. Back-to-back throughput is one command per cycle while cmd_ready_i=1.
- Stall: valid_q=1 and cmd_ready_i=0 means cmd_down_o and cmd_delta_o stay stable, and both ready outputs are 0.
- clear_i=1 at an edge: valid_q <= 0 regardless of cmd_ready_i, and no request is accepted that cycle. down_q/delta_q hold. clear_i has priority over everything except reset.
- No internal wrap-around, and there is no FSM beyond the one-entry output register.

Optional Feature:
Macro DELTA_CMD_GEN_STATS_EN.
- Defined: adds outputs issue_cnt_o [STAT_WIDTH] and cancel_cnt_o [STAT_WIDTH].
  - issue_cnt_o increments on each cmd_valid_o & cmd_ready_i.
  - cancel_cnt_o increments on each cancelled pair.
  - Both counters saturate at all-ones, reset to 0, and are zeroed by clear_i.
  - Counting does not occur in a clear_i cycle.
- Undefined: the ports and logic are absent, and the core behaviour is identical.

Test Plan:
- Reset, then inc_valid=1, inc_delta=5, cmd_ready=1 for one cycle -> next cycle cmd_valid=1, down=0, delta=5; the following cycle cmd_valid=0.
- Same cycle: inc_delta=7 and dec_delta=3, both valid -> both ready=1; next cycle one command, down=0, delta=4. Repeat with inc=2, dec=9 -> down=1, delta=7.
- inc=4 and dec=4 same cycle -> both consumed, cmd_valid stays 0; with STATS_EN, cancel_cnt_o=1 and issue_cnt_o unchanged.
- Command pending (down=1, delta=2), cmd_ready=0 for 3 cycles while inc_valid=1 -> inc_ready=0 throughout, outputs stable. Raise cmd_ready -> command transfers and inc is accepted the same cycle.
- Command pending and cmd_ready=0, assert clear_i with inc_valid=1 -> inc_ready=0; next cycle cmd_valid=0, and no inc command appears afterwards.
- Drive inc_valid=1 with inc_delta=3 for 4 cycles into a real delta_counter (WIDTH=8) with cmd_ready=1. Pull rst_ni low mid-stream -> cmd_valid_o=0 immediately, and the counter reads 0 after release.

Source files
------------

// File: rtl/delta_cmd_gen.sv
// delta_cmd_gen: nets same-cycle increment/decrement requests into one
// registered up/down delta command for the downstream counter.
// Optional statistics counters are enabled by defining DELTA_CMD_GEN_STATS_EN.
//
// Handshake: every stream uses valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both 1. A producer holds valid and
// payload stable until the transfer. Here, ready never depends on the
// valid inputs. The command output holds stable while cmd_valid_o=1 and
// cmd_ready_i=0.
`timescale 1ns/1ps

module delta_cmd_gen #(
   parameter int WIDTH      = 8,
   parameter int STAT_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  inc_valid_i,
   output logic                  inc_ready_o,
   input  logic [WIDTH-1:0]      inc_delta_i,
   input  logic                  dec_valid_i,
   output logic                  dec_ready_o,
   input  logic [WIDTH-1:0]      dec_delta_i,
   output logic                  cmd_valid_o,
   input  logic                  cmd_ready_i,
   output logic                  cmd_down_o,
   output logic [WIDTH-1:0]      cmd_delta_o
`ifdef DELTA_CMD_GEN_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] issue_cnt_o,
   output logic [STAT_WIDTH-1:0] cancel_cnt_o
`endif
);

   logic             valid_q, valid_d;
   logic             down_q, down_d;
   logic [WIDTH-1:0] delta_q, delta_d;

   logic             can_accept;
   logic             inc_fire, dec_fire;
   logic             cancel;
   logic             net_down;
   logic [WIDTH:0]   net_mag;
   logic [WIDTH:0]   inc_ext, dec_ext;
   logic [WIDTH:0]   diff_up, diff_dn;

   // The output slot is free when empty or when it drains this cycle.
   assign can_accept  = !valid_q | cmd_ready_i;
   assign inc_ready_o = can_accept & !clear_i;
   assign dec_ready_o = can_accept & !clear_i;
   assign inc_fire    = inc_valid_i & inc_ready_o;
   assign dec_fire    = dec_valid_i & dec_ready_o;

   assign inc_ext = {1'b0, inc_delta_i};
   assign dec_ext = {1'b0, dec_delta_i};
   assign diff_up = inc_ext - dec_ext;
   assign diff_dn = dec_ext - inc_ext;

   // Net the fired requests into a direction and a WIDTH+1 bit magnitude.
   always_comb begin
      net_down = 1'b0;
      net_mag  = '0;
      cancel   = 1'b0;
      if (inc_fire && dec_fire) begin
         // The borrow bit of inc-dec tells which side is larger.
         net_down = diff_up[WIDTH];
         net_mag  = diff_up[WIDTH] ? diff_dn : diff_up;
         cancel   = (inc_delta_i == dec_delta_i);
      end else if (inc_fire) begin
         net_mag  = inc_ext;
      end else if (dec_fire) begin
         net_down = 1'b1;
         net_mag  = dec_ext;
      end
   end

   // Next state of the one-entry command register; clear_i wins over accept.
   always_comb begin
      valid_d = valid_q;
      down_d  = down_q;
      delta_d = delta_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (can_accept) begin
         // A zero net magnitude consumes the request(s) without a command.
         valid_d = |net_mag;
         if (|net_mag) begin
            down_d  = net_down;
            delta_d = net_mag[WIDTH-1:0];
         end
      end
   end

   // Command register with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         down_q  <= 1'b0;
         delta_q <= '0;
      end else begin
         valid_q <= valid_d;
         down_q  <= down_d;
         delta_q <= delta_d;
      end
   end

   assign cmd_valid_o = valid_q;
   assign cmd_down_o  = down_q;
   assign cmd_delta_o = delta_q;

`ifdef DELTA_CMD_GEN_STATS_EN
   logic [STAT_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
   logic [STAT_WIDTH-1:0] cancel_cnt_q, cancel_cnt_d;

   // Saturating issue/cancel counters, flushed by clear_i.
   always_comb begin
      issue_cnt_d  = issue_cnt_q;
      cancel_cnt_d = cancel_cnt_q;
      if (clear_i) begin
         issue_cnt_d  = '0;
         cancel_cnt_d = '0;
      end else begin
         if (valid_q && cmd_ready_i && !(&issue_cnt_q))
            issue_cnt_d = issue_cnt_q + 1'b1;
         if (cancel && !(&cancel_cnt_q))
            cancel_cnt_d = cancel_cnt_q + 1'b1;
      end
   end

   // Statistics registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issue_cnt_q  <= '0;
         cancel_cnt_q <= '0;
      end else begin
         issue_cnt_q  <= issue_cnt_d;
         cancel_cnt_q <= cancel_cnt_d;
      end
   end

   assign issue_cnt_o  = issue_cnt_q;
   assign cancel_cnt_o = cancel_cnt_q;
`endif

endmodule
